core_bus_bridge: RTL and testbench

//  Bus-side master of the core_io interface: drives the core_io.out modport of one peripheral core.

---
 rtl/core_bus_bridge_pkg.sv | 16 +
 rtl/core_bus_bridge_if.sv | 24 ++
 rtl/core_bus_bridge_irq_edge_latch.sv | 30 +++
 rtl/core_bus_bridge.sv | 150 +++++++++++++++
 tb/tb_core_bus_bridge.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_bus_bridge_pkg.sv
// Shared types and helpers for the core_bus_bridge slice.
package core_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } bridge_state_t;

    localparam int unsigned IRQ_PEND_BIT = 0;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned regs);
        return addr < regs;
    endfunction

endpackage

// File: rtl/core_bus_bridge_if.sv
// core_io: register/strobe/interrupt link between a bus bridge (out) and one peripheral core (core).
interface core_io #(
    parameter int unsigned REGS = 3
) ();

    logic                      clk;
    logic                      reset;
    logic [31:0]               data_in;
    logic [REGS-1:0]           write_en;
    logic [REGS-1:0]           read_en;
    logic [REGS-1:0][31:0]     data_out;
    logic                      irq_out;

    modport out (
        output clk, reset, data_in, write_en, read_en,
        input  data_out, irq_out
    );

    modport core (
        input  clk, reset, data_in, write_en, read_en,
        output data_out, irq_out
    );

endinterface

// File: rtl/core_bus_bridge_irq_edge_latch.sv
// irq_edge_latch: sticky pending bit set on a rising edge of level_in; set wins over clear.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    input  logic clear,
    output logic pending_out
);

    logic prev_q, prev_d;
    logic pending_q, pending_d;

    always_comb begin
        prev_d    = level_in;
        pending_d = (level_in & ~prev_q) | (pending_q & ~clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending_out = pending_q;

endmodule

// File: rtl/core_bus_bridge.sv
// core_bus_bridge: single-beat bus requests to core_io strobes, registered read data/ack, irq forward.
// Optional BRIDGE_IRQ_LATCH_EN: sticky irq pending bit with a status/clear register at address REGS.
module core_bus_bridge
    import core_bridge_pkg::*;
#(
    parameter int unsigned REGS   = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ack,
    output logic              bus_err,
    output logic [31:0]       bus_rdata,
    output logic              bus_irq,
    core_io.out               io
);

    localparam int unsigned IDX_W = (REGS > 1) ? $clog2(REGS) : 1;

    bridge_state_t     state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              flag_q, flag_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [REGS-1:0]   write_en_c, read_en_c;
    logic [31:0]       data_in_c;
    logic [31:0]       addr_ext;
    logic [IDX_W-1:0]  idx;

`ifdef BRIDGE_IRQ_LATCH_EN
    logic pending;
    logic clear_c;

    irq_edge_latch u_irq_latch (
        .clk        (clk),
        .reset      (reset),
        .level_in   (io.irq_out),
        .clear      (clear_c),
        .pending_out(pending)
    );
`else
    logic irq_q, irq_d;
`endif

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        flag_d     = flag_q;
        write_en_c = '0;
        read_en_c  = '0;
        data_in_c  = '0;
        addr_ext   = 32'(addr_q);
        idx        = addr_ext[IDX_W-1:0];
`ifdef BRIDGE_IRQ_LATCH_EN
        clear_c    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus_req) begin
                    write_d = bus_write;
                    addr_d  = bus_addr;
                    wdata_d = bus_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                data_in_c = wdata_q;
                flag_d    = 1'b0;
                state_d   = RESP;
                // Range check uses every address bit, so the truncated index never aliases.
                if (in_range(addr_ext, REGS)) begin
                    write_en_c = write_q  ? (REGS'(1) << idx) : '0;
                    read_en_c  = !write_q ? (REGS'(1) << idx) : '0;
                    if (!write_q) rdata_d = io.data_out[idx];
                end
`ifdef BRIDGE_IRQ_LATCH_EN
                else if (addr_ext == REGS) begin
                    if (write_q) clear_c = wdata_q[IRQ_PEND_BIT];
                    else         rdata_d = 32'(pending);
                end
`endif
                else begin
                    flag_d  = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_q == RESP);
        err_d = (state_q == RESP) && flag_q;
`ifndef BRIDGE_IRQ_LATCH_EN
        irq_d = io.irq_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            flag_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifndef BRIDGE_IRQ_LATCH_EN
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifndef BRIDGE_IRQ_LATCH_EN
            irq_q   <= irq_d;
`endif
        end
    end

    assign io.clk      = clk;
    assign io.reset    = reset;
    assign io.data_in  = data_in_c;
    assign io.write_en = write_en_c;
    assign io.read_en  = read_en_c;

    assign bus_ack   = ack_q;
    assign bus_err   = err_q;
    assign bus_rdata = rdata_q;
`ifdef BRIDGE_IRQ_LATCH_EN
    assign bus_irq   = pending;
`else
    assign bus_irq   = irq_q;
`endif

endmodule

// File: tb/tb_core_bus_bridge.sv
// Scoreboard bench for core_bus_bridge: random bus traffic against a register-file core stand-in.
module tb_core_bus_bridge;

    localparam int unsigned REGS   = 3;
    localparam int unsigned ADDR_W = 8;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              bus_req   = 1'b0;
    logic              bus_write = 1'b0;
    logic [ADDR_W-1:0] bus_addr  = '0;
    logic [31:0]       bus_wdata = '0;
    logic              bus_ack;
    logic              bus_err;
    logic [31:0]       bus_rdata;
    logic              bus_irq;

    core_io #(.REGS(REGS)) io ();

    core_bus_bridge #(.REGS(REGS), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_req  (bus_req),
        .bus_write(bus_write),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .bus_rdata(bus_rdata),
        .bus_irq  (bus_irq),
        .io       (io)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic irq_exp   = 1'b0;
    int clr_edge    = -1;
    bit irq_run     = 1'b1;
`ifdef BRIDGE_IRQ_LATCH_EN
    logic pend_m = 1'b0;
    logic prev_m = 1'b0;
    bit   pend_log [int];
`endif

    // kind: 0 = rdata given, 1 = rdata held from previous ack, 2 = irq status read
    typedef struct { int cyc; logic err; int kind; logic [31:0] rdata; } ack_t;
    typedef struct { int cyc; logic [REGS-1:0] wr; logic [REGS-1:0] rd; logic [31:0] data; } stb_t;

    ack_t ack_q[$];
    stb_t stb_q[$];
    logic [31:0]           ref_regs [REGS];
    logic [31:0]           mon_last = '0;
    logic [REGS-1:0][31:0] core_regs;

    always @(posedge clk) begin
        if (io.reset) core_regs <= '0;
        else for (int i = 0; i < int'(REGS); i++) if (io.write_en[i]) core_regs[i] <= io.data_in;
    end
    always_comb io.data_out = core_regs;

    initial begin
        io.irq_out = 1'b0;
        while (irq_run) begin
            @(negedge clk);
            io.irq_out = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Cycle count and expected bus_irq after each clock edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
`ifdef BRIDGE_IRQ_LATCH_EN
        if (reset) begin
            pend_m = 1'b0;
            prev_m = 1'b0;
        end else begin
            pend_m = (io.irq_out && !prev_m) || (pend_m && (clr_edge != cyc));
            prev_m = io.irq_out;
        end
        pend_log[cyc] = pend_m;
        irq_exp = pend_m;
`else
        irq_exp = reset ? 1'b0 : io.irq_out;
`endif
    end

    always @(negedge clk) begin : strobe_mon
        stb_t e;
        if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
            e = stb_q.pop_front();
            chk("write_en", 32'(io.write_en), 32'(e.wr));
            chk("read_en",  32'(io.read_en),  32'(e.rd));
            chk("data_in",  io.data_in,       e.data);
        end else begin
            chk("strobes_idle", 32'({io.write_en, io.read_en}), 32'd0);
        end
        chk("bus_irq", 32'(bus_irq), 32'(irq_exp));
    end

    always @(negedge clk) begin : ack_mon
        ack_t e;
        logic [31:0] exp;
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            e = ack_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL ack_missing cyc=%0d: got no ack, expected ack at cyc %0d", cyc, e.cyc);
        end
        if (bus_ack) begin
            if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timing cyc=%0d: got ack, expected none here", cyc);
            end else begin
                e = ack_q.pop_front();
                if (e.kind == 0)      exp = e.rdata;
                else if (e.kind == 1) exp = mon_last;
`ifdef BRIDGE_IRQ_LATCH_EN
                else                  exp = 32'(pend_log[e.cyc - 2]);
`else
                else                  exp = '0;
`endif
                chk("ack_err",   32'(bus_err), 32'(e.err));
                chk("ack_rdata", bus_rdata,    exp);
                mon_last = exp;
            end
        end
    end

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit want_ack);
        ack_t ea;
        stb_t es;
        logic [REGS-1:0] one;
        int n;
        one = 1;
        n = cyc;
        bus_req = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
        ea.cyc = n + 3; ea.err = 1'b0; ea.kind = 0; ea.rdata = '0;
        if (a < REGS) begin
            es.cyc  = n + 1;
            es.wr   = w ? (one << a) : '0;
            es.rd   = w ? '0 : (one << a);
            es.data = d;
            stb_q.push_back(es);
            if (w) begin
                ref_regs[a] = d;
                ea.kind = 1;
            end else begin
                ea.rdata = ref_regs[a];
            end
        end
`ifdef BRIDGE_IRQ_LATCH_EN
        else if (a == REGS) begin
            if (w) begin
                ea.kind = 1;
                if (d[0]) clr_edge = n + 2;
            end else begin
                ea.kind = 2;
            end
        end
`endif
        else begin
            ea.err = 1'b1;
        end
        if (want_ack) ack_q.push_back(ea);
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus_ack) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout cyc=%0d: got no ack within 8 cycles, expected ack", cyc);
        end
    endtask

    initial begin
        int unsigned sel;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(REGS); i++) ref_regs[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_ack",   32'(bus_ack), 32'd0);
        chk("rst_err",   32'(bus_err), 32'd0);
        chk("rst_rdata", bus_rdata,    32'd0);
        chk("rst_irq",   32'(bus_irq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b1, 8'd0, 32'h0000_1234, 1'b1); wait_ack();
        issue(1'b0, 8'd0, 32'h0, 1'b1);         wait_ack();
        issue(1'b1, 8'd1, 32'h0000_0003, 1'b1); wait_ack();
        issue(1'b0, 8'd5, 32'hDEAD_BEEF, 1'b1); wait_ack();
        issue(1'b0, 8'(REGS), 32'h0, 1'b1);     wait_ack();
        issue(1'b0, 8'h80, 32'h0, 1'b1);        wait_ack();
        issue(1'b0, 8'd0, 32'h0, 1'b1);         wait_ack();
        issue(1'b1, 8'd2, 32'hA5A5_0F0F, 1'b1); wait_ack();
        for (int t = 0; t < 4; t++) begin
            issue(1'b0, 8'd1, 32'h0, 1'b1);
            wait_ack();
        end

        // Reset lands during ACCESS of a read: the transaction must vanish without an ack.
        bus_req = 1'b0;
        @(negedge clk);
        issue(1'b0, 8'd2, 32'h0, 1'b0);
        @(negedge clk);
        bus_req = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_strobes", 32'({io.write_en, io.read_en}), 32'd0);
        chk("rst_mid_ack",     32'(bus_ack), 32'd0);
        chk("rst_mid_rdata",   bus_rdata,    32'd0);
        for (int i = 0; i < int'(REGS); i++) ref_regs[i] = '0;
        mon_last = '0;
        clr_edge = -1;
        @(negedge clk);
        issue(1'b0, 8'd1, 32'h0, 1'b1); wait_ack();

        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                bus_req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            sel = $urandom_range(0, 9);
            a = (sel <= 5) ? ADDR_W'(sel) : ADDR_W'($urandom_range(6, 255));
            issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            wait_ack();
        end

        bus_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("ack_queue_drained",    32'(ack_q.size()), 32'd0);
        chk("strobe_queue_drained", 32'(stb_q.size()), 32'd0);
        irq_run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
